bin_clock_core: RTL and testbench

BIN_CLOCK_CORE -- requirements
Module: bin_clock_core

---
 rtl/bin_clock_core.sv | 163 ++++++++++++++++
 tb/tb_bin_clock_core.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/bin_clock_core.sv
// Binary time-of-day core: seconds prescaler, hh:mm:ss counters with carry chain,
// debounced set-mode buttons and a registered display multiplexer.
module bin_clock_core #(
    parameter int PRESCALE = 10000000,
    parameter int DEBOUNCE = 65536
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       run,
    input  logic       inc_min,
    input  logic       inc_hr,
    input  logic [1:0] sel,
    output logic [5:0] ss,
    output logic [5:0] mm,
    output logic [4:0] hh,
    output logic       sec_tick,
    output logic [7:0] disp
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    logic [1:0] btn_raw;
    logic [1:0] btn_lvl;
    logic [1:0] btn_pulse;
    logic [1:0] vld_q;

    assign btn_raw = {inc_hr, inc_min};

    // Synchronizer contents are only trusted once both stages hold real samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 2'b00;
        end else begin
            vld_q <= {vld_q[0], 1'b1};
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            logic          meta_q;
            logic          sync_q;
            logic          acc_q;
            logic          arm_q;
            logic [DW-1:0] cnt_q;
            logic          accept;

            assign accept        = (sync_q != acc_q) && (cnt_q == DW'(DEBOUNCE - 1));
            // A press only counts once the button has been seen released since reset.
            assign btn_pulse[gi] = accept && sync_q && arm_q;
            assign btn_lvl[gi]   = acc_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    meta_q <= 1'b0;
                    sync_q <= 1'b0;
                    acc_q  <= 1'b0;
                    arm_q  <= 1'b0;
                    cnt_q  <= '0;
                end else begin
                    meta_q <= btn_raw[gi];
                    sync_q <= meta_q;
                    if (vld_q[1] && !sync_q) begin
                        arm_q <= 1'b1;
                    end
                    if (sync_q == acc_q) begin
                        cnt_q <= '0;
                    end else if (accept) begin
                        acc_q <= sync_q;
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
            end
        end
    endgenerate

    logic [PW-1:0] pre_q, pre_d;
    logic [5:0]    ss_q, ss_d;
    logic [5:0]    mm_q, mm_d;
    logic [4:0]    hh_q, hh_d;
    logic          blink_q, blink_d;
    logic          tick_q, tick_d;
    logic [7:0]    disp_q, disp_d;

    always_comb begin
        pre_d   = pre_q;
        ss_d    = ss_q;
        mm_d    = mm_q;
        hh_d    = hh_q;
        blink_d = blink_q;
        tick_d  = 1'b0;
        if (!run) begin
            pre_d = '0;
            ss_d  = 6'd0;
            if (btn_pulse[0]) begin
                mm_d = (mm_q == 6'd59) ? 6'd0 : mm_q + 6'd1;
            end
            if (btn_pulse[1]) begin
                hh_d = (hh_q == 5'd23) ? 5'd0 : hh_q + 5'd1;
            end
        end else if (ena) begin
            if (pre_q == PW'(PRESCALE - 1)) begin
                pre_d   = '0;
                tick_d  = 1'b1;
                blink_d = ~blink_q;
                if (ss_q == 6'd59) begin
                    ss_d = 6'd0;
                    if (mm_q == 6'd59) begin
                        mm_d = 6'd0;
                        hh_d = (hh_q == 5'd23) ? 5'd0 : hh_q + 5'd1;
                    end else begin
                        mm_d = mm_q + 6'd1;
                    end
                end else begin
                    ss_d = ss_q + 6'd1;
                end
            end else begin
                pre_d = pre_q + 1'b1;
            end
        end
    end

    always_comb begin
        disp_d = 8'h00;
        case (sel)
            2'd0: disp_d = {2'b00, ss_q};
            2'd1: disp_d = {2'b00, mm_q};
            2'd2: disp_d = {3'b000, hh_q};
            default: disp_d = {ena, run, btn_lvl[1], btn_lvl[0], 3'b000, blink_q};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q   <= '0;
            ss_q    <= 6'd0;
            mm_q    <= 6'd0;
            hh_q    <= 5'd0;
            blink_q <= 1'b0;
            tick_q  <= 1'b0;
            disp_q  <= 8'h00;
        end else begin
            pre_q   <= pre_d;
            ss_q    <= ss_d;
            mm_q    <= mm_d;
            hh_q    <= hh_d;
            blink_q <= blink_d;
            tick_q  <= tick_d;
            disp_q  <= disp_d;
        end
    end

    // The pulse is masked so it can never appear while counting is stopped.
    assign sec_tick = tick_q & ena & run;
    assign ss       = ss_q;
    assign mm       = mm_q;
    assign hh       = hh_q;
    assign disp     = disp_q;

endmodule

// File: tb/tb_bin_clock_core.sv
// Directed bench for bin_clock_core with PRESCALE=4, DEBOUNCE=3.
module tb_bin_clock_core;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       run;
    logic       inc_min;
    logic       inc_hr;
    logic [1:0] sel;
    logic [5:0] ss;
    logic [5:0] mm;
    logic [4:0] hh;
    logic       sec_tick;
    logic [7:0] disp;

    int n_cmp  = 0;
    int n_fail = 0;

    bin_clock_core #(.PRESCALE(4), .DEBOUNCE(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .run      (run),
        .inc_min  (inc_min),
        .inc_hr   (inc_hr),
        .sel      (sel),
        .ss       (ss),
        .mm       (mm),
        .hh       (hh),
        .sec_tick (sec_tick),
        .disp     (disp)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic m, input logic h);
        inc_min = m;
        inc_hr  = h;
        step(6);
        inc_min = 1'b0;
        inc_hr  = 1'b0;
        step(6);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; ena = 1'b0; run = 1'b0;
        inc_min = 1'b0; inc_hr = 1'b0; sel = 2'd0;
        #2;
        n_cmp++; if (ss !== 6'd0) begin n_fail++; $display("FAIL reset_ss got %0d want 0", ss); end
        n_cmp++; if (mm !== 6'd0) begin n_fail++; $display("FAIL reset_mm got %0d want 0", mm); end
        n_cmp++; if (hh !== 5'd0) begin n_fail++; $display("FAIL reset_hh got %0d want 0", hh); end
        n_cmp++; if (sec_tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick got %b want 0", sec_tick); end
        n_cmp++; if (disp !== 8'h00) begin n_fail++; $display("FAIL reset_disp got %h want 00", disp); end
        $display("test_reset done");
    endtask

    task automatic test_run_ticks;
        @(posedge clk); #1;
        run = 1'b1; ena = 1'b1; sel = 2'd3; rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step(1);
            n_cmp++;
            if (sec_tick !== ((k % 4) == 0)) begin
                n_fail++;
                $display("FAIL tick_pattern cycle %0d got %b want %b", k, sec_tick, ((k % 4) == 0));
            end
        end
        n_cmp++; if (ss !== 6'd4) begin n_fail++; $display("FAIL ticks_ss got %0d want 4", ss); end
        ena = 1'b0;
        step(1);
        n_cmp++; if (disp !== 8'h40) begin n_fail++; $display("FAIL ticks_status got %h want 40", disp); end
        n_cmp++; if (sec_tick !== 1'b0) begin n_fail++; $display("FAIL ticks_ena0 got %b want 0", sec_tick); end
        $display("test_run_ticks done");
    endtask

    task automatic test_rollover;
        run = 1'b0;
        step(2);
        for (int i = 0; i < 23; i++) press(1'b1, 1'b1);
        for (int i = 0; i < 36; i++) press(1'b1, 1'b0);
        n_cmp++; if (mm !== 6'd59) begin n_fail++; $display("FAIL preload_mm got %0d want 59", mm); end
        n_cmp++; if (hh !== 5'd23) begin n_fail++; $display("FAIL preload_hh got %0d want 23", hh); end
        sel = 2'd2; run = 1'b1; ena = 1'b1;
        step(239);
        n_cmp++; if (ss !== 6'd59) begin n_fail++; $display("FAIL pre_roll_ss got %0d want 59", ss); end
        step(1);
        n_cmp++; if ({hh, mm, ss} !== 17'd0) begin n_fail++; $display("FAIL roll_time got %0d:%0d:%0d want 0:0:0", hh, mm, ss); end
        n_cmp++; if (sec_tick !== 1'b1) begin n_fail++; $display("FAIL roll_tick got %b want 1", sec_tick); end
        n_cmp++; if (disp !== 8'd23) begin n_fail++; $display("FAIL roll_disp_old got %0d want 23", disp); end
        step(1);
        n_cmp++; if (disp !== 8'd0) begin n_fail++; $display("FAIL roll_disp_new got %0d want 0", disp); end
        $display("test_rollover done");
    endtask

    task automatic test_set_buttons;
        run = 1'b0;
        step(2);
        n_cmp++; if (ss !== 6'd0) begin n_fail++; $display("FAIL set_ss_clear got %0d want 0", ss); end
        inc_min = 1'b1; step(1); inc_min = 1'b0; step(8);
        n_cmp++; if (mm !== 6'd0) begin n_fail++; $display("FAIL glitch_mm got %0d want 0", mm); end
        inc_min = 1'b1; step(10);
        n_cmp++; if (mm !== 6'd1) begin n_fail++; $display("FAIL hold_mm got %0d want 1", mm); end
        inc_min = 1'b0; step(6);
        n_cmp++; if (mm !== 6'd1) begin n_fail++; $display("FAIL release_mm got %0d want 1", mm); end
        for (int i = 0; i < 59; i++) press(1'b1, 1'b0);
        n_cmp++; if (mm !== 6'd0) begin n_fail++; $display("FAIL wrap_mm got %0d want 0", mm); end
        n_cmp++; if (hh !== 5'd0) begin n_fail++; $display("FAIL wrap_hh got %0d want 0", hh); end
        $display("test_set_buttons done");
    endtask

    task automatic test_run_discard;
        run = 1'b1; ena = 1'b1;
        inc_hr = 1'b1; step(20);
        n_cmp++; if (hh !== 5'd0) begin n_fail++; $display("FAIL discard_hh got %0d want 0", hh); end
        n_cmp++; if (ss !== 6'd5) begin n_fail++; $display("FAIL discard_ss got %0d want 5", ss); end
        inc_hr = 1'b0; step(6);
        n_cmp++; if (ss !== 6'd6) begin n_fail++; $display("FAIL midsec_ss got %0d want 6", ss); end
        ena = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step(1);
            n_cmp++; if (sec_tick !== 1'b0) begin n_fail++; $display("FAIL frozen_tick cycle %0d got %b want 0", k, sec_tick); end
        end
        n_cmp++; if (ss !== 6'd6) begin n_fail++; $display("FAIL frozen_ss got %0d want 6", ss); end
        ena = 1'b1;
        step(1);
        n_cmp++; if (sec_tick !== 1'b0) begin n_fail++; $display("FAIL resume1_tick got %b want 0", sec_tick); end
        step(1);
        n_cmp++; if (sec_tick !== 1'b1) begin n_fail++; $display("FAIL resume2_tick got %b want 1", sec_tick); end
        n_cmp++; if (ss !== 6'd7) begin n_fail++; $display("FAIL resume_ss got %0d want 7", ss); end
        n_cmp++; if (hh !== 5'd0) begin n_fail++; $display("FAIL resume_hh got %0d want 0", hh); end
        $display("test_run_discard done");
    endtask

    task automatic test_sel_sweep;
        run = 1'b0;
        step(2);
        for (int i = 0; i < 5; i++) press(1'b1, 1'b1);
        for (int i = 0; i < 2; i++) press(1'b1, 1'b0);
        sel = 2'd0; run = 1'b1; ena = 1'b1;
        step(36);
        n_cmp++; if ({hh, mm, ss} !== {5'd5, 6'd7, 6'd9}) begin n_fail++; $display("FAIL sweep_time got %0d:%0d:%0d want 5:7:9", hh, mm, ss); end
        sel = 2'd0; step(1);
        n_cmp++; if (disp !== 8'h09) begin n_fail++; $display("FAIL sweep_sel0 got %h want 09", disp); end
        sel = 2'd1; step(1);
        n_cmp++; if (disp !== 8'h07) begin n_fail++; $display("FAIL sweep_sel1 got %h want 07", disp); end
        sel = 2'd2; step(1);
        n_cmp++; if (disp !== 8'h05) begin n_fail++; $display("FAIL sweep_sel2 got %h want 05", disp); end
        sel = 2'd3; step(1);
        n_cmp++; if (disp !== 8'hC0) begin n_fail++; $display("FAIL sweep_sel3 got %h want c0", disp); end
        $display("test_sel_sweep done");
    endtask

    task automatic test_async_reset;
        run = 1'b0; sel = 2'd0;
        step(2);
        for (int i = 0; i < 7; i++) press(1'b1, 1'b1);
        for (int i = 0; i < 20; i++) press(1'b1, 1'b0);
        inc_min = 1'b1; inc_hr = 1'b1; run = 1'b1; ena = 1'b1;
        step(224);
        n_cmp++; if ({hh, mm, ss} !== {5'd12, 6'd34, 6'd56}) begin n_fail++; $display("FAIL pre_reset_time got %0d:%0d:%0d want 12:34:56", hh, mm, ss); end
        #3;
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({hh, mm, ss} !== 17'd0) begin n_fail++; $display("FAIL async_time got %0d:%0d:%0d want 0:0:0", hh, mm, ss); end
        n_cmp++; if (sec_tick !== 1'b0) begin n_fail++; $display("FAIL async_tick got %b want 0", sec_tick); end
        n_cmp++; if (disp !== 8'h00) begin n_fail++; $display("FAIL async_disp got %h want 00", disp); end
        @(posedge clk); #1;
        rst_n = 1'b1; run = 1'b0;
        step(12);
        n_cmp++; if (mm !== 6'd0) begin n_fail++; $display("FAIL held_mm got %0d want 0", mm); end
        n_cmp++; if (hh !== 5'd0) begin n_fail++; $display("FAIL held_hh got %0d want 0", hh); end
        inc_min = 1'b0; inc_hr = 1'b0;
        step(6);
        press(1'b1, 1'b1);
        n_cmp++; if (mm !== 6'd1) begin n_fail++; $display("FAIL repress_mm got %0d want 1", mm); end
        n_cmp++; if (hh !== 5'd1) begin n_fail++; $display("FAIL repress_hh got %0d want 1", hh); end
        $display("test_async_reset done");
    endtask

    initial begin
        test_reset;
        test_run_ticks;
        test_rollover;
        test_set_buttons;
        test_run_discard;
        test_sel_sweep;
        test_async_reset;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
